watchdog_seq_ctrl: RTL and testbench

WATCHDOG_SEQ_CTRL -- requirements
Module: watchdog_seq_ctrl

---
 rtl/watchdog_pkg.sv | 51 +++++
 rtl/wd_timer.sv | 48 ++++
 rtl/watchdog_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_watchdog_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared types, defaults and helpers for the watchdog sequencing controller.
`timescale 1ns/1ps
package watchdog_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 200;
  localparam int unsigned ACK_WIN_DEF     = 4;
  localparam int unsigned CNT_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CORE_START = 3'd1,
    ST_CORE_ACK   = 3'd2,
    ST_CORE_RUN   = 3'd3,
    ST_OL_START   = 3'd4,
    ST_OL_ACK     = 3'd5,
    ST_OL_RUN     = 3'd6,
    ST_ERR        = 3'd7
  } wd_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CORE_ACK = 3'd1,
    ERR_CORE_RUN = 3'd2,
    ERR_OL_ACK   = 3'd3,
    ERR_OL_RUN   = 3'd4
  } wd_err_code_e;

  // Reported error code for a state that timed out; non-waiting states map to none.
  function automatic logic [2:0] err_code_of(input wd_state_e st);
    logic [2:0] code;
    case (st)
      ST_CORE_ACK: code = ERR_CORE_ACK;
      ST_CORE_RUN: code = ERR_CORE_RUN;
      ST_OL_ACK:   code = ERR_OL_ACK;
      ST_OL_RUN:   code = ERR_OL_RUN;
      default:     code = ERR_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_ack_state(input wd_state_e st);
    logic res;
    case (st)
      ST_CORE_ACK: res = 1'b1;
      ST_OL_ACK:   res = 1'b1;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wd_timer.sv
// Per-state cycle counter: cleared on state entry, frozen while disabled,
// flags the cycle on which the state has been occupied for 'limit' cycles.
`timescale 1ns/1ps
module wd_timer
  import watchdog_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The first cycle in a state sees count 0, so the limit-th cycle sees limit-1.
  always_comb begin
    if (limit == {CNT_W{1'b0}}) begin
      expired = 1'b1;
    end else begin
      expired = (cnt_q >= (limit - {{(CNT_W-1){1'b0}}, 1'b1}));
    end
  end

  // Next count: clear wins, then saturating increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && !expired) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/watchdog_seq_ctrl.sv
// Sequences one eig_core run followed by one output_loader run per accepted
// parameter pair, with handshake and run-time watchdogs and a sticky error.
`timescale 1ns/1ps
module watchdog_seq_ctrl
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned ACK_WIN     = ACK_WIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       core_start,
  input  logic       core_busy,
  output logic       res_valid,
  output logic       ol_start,
  input  logic       ol_busy,
  input  logic       clr_err,
  output logic       seq_busy,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] run_cnt
);

  wd_state_e        state_q;
  wd_state_e        state_d;
  logic             err_q;
  logic             err_d;
  logic [2:0]       err_code_q;
  logic [2:0]       err_code_d;
  logic [7:0]       run_cnt_q;
  logic [7:0]       run_cnt_d;

  logic             timeout_s;
  logic             done_s;
  logic             tmr_clear_s;
  logic             tmr_expired_s;
  logic [CNT_W-1:0] tmr_limit_s;

  wd_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear_s),
    .enable  (ena),
    .limit   (tmr_limit_s),
    .expired (tmr_expired_s)
  );

  // Handshake states use the short ack window, everything else the run timeout.
  always_comb begin
    if (is_ack_state(state_q)) begin
      tmr_limit_s = CNT_W'(ACK_WIN);
    end else begin
      tmr_limit_s = CNT_W'(TIMEOUT_CYC);
    end
  end

  // Any state change restarts the per-state count.
  always_comb begin
    if (state_d != state_q) begin
      tmr_clear_s = 1'b1;
    end else begin
      tmr_clear_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a busy line seen low always beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (pl_valid && !err_q) begin
            state_d = ST_CORE_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CORE_START: state_d = ST_CORE_ACK;
        ST_CORE_ACK: begin
          if (core_busy) begin
            state_d = ST_CORE_RUN;
          end else if (tmr_expired_s) begin
            state_d   = ST_ERR;
            timeout_s = 1'b1;
          end else begin
            state_d = ST_CORE_ACK;
          end
        end
        ST_CORE_RUN: begin
          if (!core_busy) begin
            state_d = ST_OL_START;
          end else if (tmr_expired_s) begin
            state_d   = ST_ERR;
            timeout_s = 1'b1;
          end else begin
            state_d = ST_CORE_RUN;
          end
        end
        ST_OL_START: state_d = ST_OL_ACK;
        ST_OL_ACK: begin
          if (ol_busy) begin
            state_d = ST_OL_RUN;
          end else if (tmr_expired_s) begin
            state_d   = ST_ERR;
            timeout_s = 1'b1;
          end else begin
            state_d = ST_OL_ACK;
          end
        end
        ST_OL_RUN: begin
          if (!ol_busy) begin
            state_d = ST_IDLE;
            done_s  = 1'b1;
          end else if (tmr_expired_s) begin
            state_d   = ST_ERR;
            timeout_s = 1'b1;
          end else begin
            state_d = ST_OL_RUN;
          end
        end
        ST_ERR: begin
          if (clr_err) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sticky error and run counter updates; clr_err only acts from ERR.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    run_cnt_d  = run_cnt_q;
    if (timeout_s) begin
      err_d      = 1'b1;
      err_code_d = err_code_of(state_q);
    end else if (ena && (state_q == ST_ERR) && clr_err) begin
      err_d      = 1'b0;
      err_code_d = 3'd0;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
    if (done_s) begin
      run_cnt_d = run_cnt_q + 8'd1;
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      run_cnt_q  <= 8'd0;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  // Outputs; pulses are gated by ena so a frozen pulse lands on the next enabled cycle.
  always_comb begin
    pl_ready   = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    ol_start   = 1'b0;
    if (state_q != ST_IDLE) begin
      seq_busy = 1'b1;
    end else begin
      seq_busy = 1'b0;
    end
    if (ena) begin
      case (state_q)
        ST_IDLE:       pl_ready   = !err_q;
        ST_CORE_START: core_start = 1'b1;
        ST_CORE_RUN:   res_valid  = !core_busy;
        ST_OL_START:   ol_start   = 1'b1;
        default:       pl_ready   = 1'b0;
      endcase
    end else begin
      pl_ready = 1'b0;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_watchdog_seq_ctrl.sv
// Randomized scoreboard bench: each run's expected pulse/error/count events are
// computed from the handshake timing rules and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_watchdog_seq_ctrl;

  localparam int TMO = 200;
  localparam int AW  = 4;

  localparam int EV_CS   = 0;
  localparam int EV_RV   = 1;
  localparam int EV_OS   = 2;
  localparam int EV_ERR  = 3;
  localparam int EV_CLR  = 4;
  localparam int EV_DONE = 5;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, ena, pl_valid, core_busy, ol_busy, clr_err;
  logic       pl_ready, core_start, res_valid, ol_start, seq_busy, err;
  logic [2:0] err_code;
  logic [7:0] run_cnt;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  exp_cnt = 0;
  bit  mon_en = 1'b0;
  ev_t sb[$];
  logic       err_prev;
  logic [7:0] cnt_prev;

  watchdog_seq_ctrl #(.TIMEOUT_CYC(TMO), .ACK_WIN(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .core_start(core_start), .core_busy(core_busy), .res_valid(res_valid),
    .ol_start(ol_start), .ol_busy(ol_busy), .clr_err(clr_err), .seq_busy(seq_busy),
    .err(err), .err_code(err_code), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic string kname(input int k);
    case (k)
      EV_CS:   return "core_start";
      EV_RV:   return "res_valid";
      EV_OS:   return "ol_start";
      EV_ERR:  return "err_set";
      EV_CLR:  return "err_clear";
      default: return "run_done";
    endcase
  endfunction

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic match(input int kind, input int val);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].kind == kind) idx = i;
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event at cycle %0d value %0d", kname(kind), cyc, val);
    end else begin
      if (sb[idx].cyc != cyc || sb[idx].val != val) begin
        miscompares++;
        $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
                 kname(kind), cyc, val, sb[idx].cyc, sb[idx].val);
      end
      sb.delete(idx);
    end
  endtask

  // Monitor: every observable event is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_start === 1'b1) match(EV_CS, 0);
      if (res_valid === 1'b1)  match(EV_RV, 0);
      if (ol_start === 1'b1)   match(EV_OS, 0);
      if (err === 1'b1 && err_prev === 1'b0) match(EV_ERR, int'(err_code));
      if (err === 1'b0 && err_prev === 1'b1) match(EV_CLR, int'(err_code));
      if (run_cnt !== cnt_prev) match(EV_DONE, int'(run_cnt));
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL %s: missing, expected at cycle %0d value %0d (now %0d)",
                   kname(sb[i].kind), sb[i].cyc, sb[i].val, cyc);
          sb.delete(i);
        end
      end
    end
    err_prev = err;
    cnt_prev = run_cnt;
  end

  task automatic idle_inputs();
    ena = 1'b1; pl_valid = 1'b0; core_busy = 1'b0; ol_busy = 1'b0; clr_err = 1'b0;
  endtask

  // Timing of one start/ack/run handshake whose start pulse lands on cycle st.
  // Busy is high for l cycles beginning a cycles after the pulse (a > AW: never).
  task automatic phase(input int st, input int a, input int l, input int fz,
                       output int done, output bit t_ack, output bit t_run);
    int rs;
    t_ack = 1'b0;
    t_run = 1'b0;
    if (a > AW) begin
      t_ack = 1'b1;
      done  = st + AW + fz;
    end else begin
      rs   = st + ((a == 0) ? 1 : a) + 1;
      done = st + a + l;
      if (done >= rs + TMO) begin
        t_run = 1'b1;
        done  = rs + TMO - 1;
      end
    end
  endtask

  // One transaction from IDLE: f1 frozen cycles in CORE_START, f2 frozen cycles inside CORE_ACK.
  task automatic run(input int a, input int l, input int b, input int m, input int f1, input int f2);
    int n, s, s2, d1, d2, e, code;
    bit ta, tr, errrun;
    n = cyc;
    s = n + 1 + f1;
    s2 = 32'h3fff_0000;
    errrun = 1'b0;
    code = 0;
    push(EV_CS, s, 0);
    phase(s, a, l, f2, d1, ta, tr);
    if (ta || tr) begin
      errrun = 1'b1; e = d1; code = ta ? 1 : 2;
    end else begin
      push(EV_RV, d1, 0);
      s2 = d1 + 1;
      push(EV_OS, s2, 0);
      phase(s2, b, m, 0, d2, ta, tr);
      e = d2;
      if (ta || tr) begin
        errrun = 1'b1; code = ta ? 3 : 4;
      end else begin
        exp_cnt = (exp_cnt + 1) % 256;
        push(EV_DONE, d2 + 1, exp_cnt);
      end
    end
    if (errrun) push(EV_ERR, e + 1, code);
    for (int c = n; c <= e; c++) begin
      ena       = !((c >= n + 1 && c <= n + f1) || (c >= s + 2 && c <= s + 1 + f2));
      pl_valid  = (c == n) ? 1'b1 : 1'($urandom & 32'd1);
      core_busy = (a <= AW) && (c >= s + a) && (c <= s + a + l - 1);
      ol_busy   = (b <= AW) && (c >= s2 + b) && (c <= s2 + b + m - 1);
      clr_err   = (errrun && c == e) ? 1'b1 : 1'($urandom & 32'd1);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // From the first ERR cycle: error holds off new work, ignores a frozen clear, then clears.
  task automatic clear_err();
    pl_valid = 1'b1;
    repeat (3) begin
      chk("err_pl_ready", int'(pl_ready), 0);
      chk("err_seq_busy", int'(seq_busy), 1);
      @(posedge clk); #1;
    end
    ena = 1'b0; clr_err = 1'b1;
    @(posedge clk); #1;
    chk("err_frozen_clear", int'(err), 1);
    ena = 1'b1; clr_err = 1'b1; pl_valid = 1'b0;
    push(EV_CLR, cyc + 1, 0);
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clear_pl_ready", int'(pl_ready), 1);
  endtask

  initial begin
    int n, s;
    idle_inputs();
    rst = 1'b1; clr_err = 1'b1; pl_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seq_busy", int'(seq_busy), 0);
    rst = 1'b0; clr_err = 1'b0; pl_valid = 1'b0;
    #1;
    chk("rst_core_start", int'(core_start), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_ol_start", int'(ol_start), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_run_cnt", int'(run_cnt), 0);
    chk("rst_pl_ready", int'(pl_ready), 1);
    ena = 1'b0; #1;
    chk("ena_low_pl_ready", int'(pl_ready), 0);
    ena = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    run(1, 10, 1, 6, 0, 0);                 // nominal
    chk("nominal_idle", int'(seq_busy), 0);
    run(0, 5, 0, 4, 0, 0);                  // busy rises with the start pulse
    run(2, 4, 1, 3, 5, 0);                  // freeze in CORE_START
    run(AW, 3, AW, 3, 0, 0);                // ack on the last allowed cycle
    run(1, TMO, 1, 2, 0, 0);                // run ends on the last allowed cycle
    run(99, 1, 0, 0, 0, 3);                 // core never acks, freeze inside the window
    clear_err();
    run(1, TMO + 1, 0, 0, 0, 0);            // core run timeout
    clear_err();
    run(1, 3, 99, 1, 0, 0);                 // output loader never acks
    clear_err();
    run(1, 3, 1, 1000, 0, 0);               // output loader stuck, clear races timeout
    clear_err();
    for (int i = 0; i < 20; i++)
      run(int'($urandom_range(AW, 0)), int'($urandom_range(12, 2)),
          int'($urandom_range(AW, 0)), int'($urandom_range(12, 2)),
          int'($urandom_range(3, 0)), 0);

    // Reset in the middle of OL_RUN, with ena low and clr_err high.
    mon_en = 1'b0;
    n = cyc; s = n + 1;
    for (int c = n; c <= s + 12; c++) begin
      pl_valid  = (c == n);
      core_busy = (c >= s + 1 && c <= s + 3);
      ol_busy   = (c >= s + 6);
      @(posedge clk); #1;
    end
    chk("midrst_busy_before", int'(seq_busy), 1);
    chk("midrst_cnt_before", int'(run_cnt), exp_cnt);
    rst = 1'b1; ena = 1'b0; clr_err = 1'b1; pl_valid = 1'b1;
    @(posedge clk); #1;
    chk("midrst_seq_busy", int'(seq_busy), 0);
    chk("midrst_run_cnt", int'(run_cnt), 0);
    chk("midrst_pulses", int'({core_start, res_valid, ol_start}), 0);
    chk("midrst_err", int'(err), 0);
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 256; i++)
      run(int'($urandom_range(2, 1)), int'($urandom_range(4, 2)),
          int'($urandom_range(2, 1)), int'($urandom_range(4, 2)), 0, 0);
    chk("wrap_run_cnt", int'(run_cnt), 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: never seen, expected at cycle %0d", kname(sb[0].kind), sb[0].cyc);
      sb.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
